kernel_address_scanner: RTL and testbench
=========================================

KERNEL_ADDRESS_SCANNER -- requirements
Module: kernel_address_scanner

Interface
REQ-001 SHALL have parameter IMG_W, default 8, image width in pixels (2..2^AW_W-1).
REQ-002 SHALL have parameter IMG_D, default 8, image depth (rows) in pixels (2..2^AD_W-1).
REQ-003 SHALL have parameter AW_W, default 8, width-address bit width.
REQ-004 SHALL have parameter AD_W, default 8, depth-address bit width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a frame scan.
REQ-008 SHALL have port out_ready, input, 1, downstream neighbour-address stage can accept.
REQ-009 SHALL have port out_valid, output, 1, address pair on outputs is valid.
REQ-010 SHALL have port address_width, output, AW_W, current column index.
REQ-011 SHALL have port address_depth, output, AD_W, current row index.
REQ-012 SHALL have port last, output, 1, high with the final address of the frame.
REQ-013 SHALL have port busy, output, 1, high from accepted start until frame completion.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse after the last transfer.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-016 IDLE: start=1 -> SCAN next cycle, counters loaded with first coordinate; start ignored in SCAN/DONE.
REQ-017 SCAN: out_valid=1 continuously; transfer occurs when out_valid && out_ready.
REQ-018 On transfer, address_width increments; on column wrap (width = last column) it returns to first column and address_depth increments.
REQ-019 Outputs SHALL hold stable while out_valid=1 and out_ready=0 (no drop, no skip).
REQ-020 last SHALL be high exactly when both counters equal their last coordinates and out_valid=1.
REQ-021 Transfer with last=1 -> DONE; out_valid deasserts next cycle.
REQ-022 DONE: frame_done=1 for one cycle, then IDLE; busy=0 in IDLE only.
REQ-023 Scan order SHALL be row-major, width fastest; first output appears one cycle after start.
REQ-024 Counters SHALL never exceed last coordinate; no arithmetic wrap beyond parameter bounds.
REQ-025 Throughput SHALL be one address per cycle with out_ready held high.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, address_width=0, address_depth=0, out_valid=0, last=0, busy=0, frame_done=0.
REQ-027 Reset mid-scan SHALL abandon the frame with no frame_done pulse; a new start is needed after release.

Configuration
REQ-028 Macro KERNEL_SCAN_BORDER_SKIP_EN defined: scan covers columns 1..IMG_W-2 and rows 0..IMG_D-2, so downstream width-1/width+1/depth+1 stay in-image.
REQ-029 Macro undefined: scan covers columns 0..IMG_W-1 and rows 0..IMG_D-1; border handling is downstream's job.
REQ-030 With macro defined, IMG_W SHALL be >=3; otherwise elaboration error.

Structure
REQ-031 A shared package kernel_pkg SHALL hold the scan_state_t enum (IDLE, SCAN, DONE) and default AW_W/AD_W constants.
REQ-032 One sub-module kernel_scan_counter (loadable, enable, wrap-at-limit counter with terminal flag) SHALL be instantiated twice, width and depth.

Verification
REQ-033 IMG_W=4, IMG_D=3, no macro, out_ready=1, start pulse -> 12 pairs (0,0),(1,0)..(3,2), last on (3,2), frame_done one cycle after.
REQ-034 Same config, out_ready toggled 1/0 each cycle -> identical 12-pair sequence, outputs held during stalls, 23 cycles valid.
REQ-035 Macro defined, IMG_W=4, IMG_D=3 -> pairs (1,0),(2,0),(1,1),(2,1), last on (2,1).
REQ-036 rst_n low after 5 transfers -> all outputs 0 asynchronously, no frame_done; new start restarts at (0,0).
REQ-037 start pulsed during SCAN -> ignored, sequence unchanged; start in DONE cycle -> ignored, frame needs start in IDLE.
REQ-038 IMG_W=2, IMG_D=2, out_ready=0 for 10 cycles after start -> (0,0) held valid 10 cycles, then 4 pairs on release.

Source files
------------

// File: rtl/kernel_pkg.sv
// rtl/kernel_pkg.sv - shared scan state type and default address widths for the kernel address scanner
package kernel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam int DEFAULT_AW_W = 8;
  localparam int DEFAULT_AD_W = 8;

endpackage

// File: rtl/kernel_scan_counter.sv
// rtl/kernel_scan_counter.sv - loadable enabled counter running FIRST..LAST, wrapping to FIRST, with terminal flag
module kernel_scan_counter #(
  parameter int           W     = 8,
  parameter logic [W-1:0] FIRST = '0,
  parameter logic [W-1:0] LAST  = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign term_o = (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  // Wrap on the terminal value so the count never walks past LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = FIRST;
    end else if (en_i) begin
      cnt_d = term_o ? FIRST : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/kernel_address_scanner.sv
// rtl/kernel_address_scanner.sv - row-major frame address scanner; KERNEL_SCAN_BORDER_SKIP_EN trims border columns and the last row
module kernel_address_scanner
  import kernel_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_D = 8,
  parameter int AW_W  = DEFAULT_AW_W,
  parameter int AD_W  = DEFAULT_AD_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [AW_W-1:0] address_width,
  output logic [AD_W-1:0] address_depth,
  output logic            last,
  output logic            busy,
  output logic            frame_done
);

`ifdef KERNEL_SCAN_BORDER_SKIP_EN
  localparam int FIRST_W = 1;
  localparam int LAST_W  = IMG_W - 2;
  localparam int LAST_D  = IMG_D - 2;
  if (IMG_W < 3) begin : g_bad_border_w
    $error("kernel_address_scanner: IMG_W must be >= 3 when border skip is enabled");
  end
`else
  localparam int FIRST_W = 0;
  localparam int LAST_W  = IMG_W - 1;
  localparam int LAST_D  = IMG_D - 1;
`endif

  if (IMG_W < 2 || IMG_W > (2 ** AW_W) - 1) begin : g_bad_img_w
    $error("kernel_address_scanner: IMG_W out of range for AW_W");
  end
  if (IMG_D < 2 || IMG_D > (2 ** AD_W) - 1) begin : g_bad_img_d
    $error("kernel_address_scanner: IMG_D out of range for AD_W");
  end

  scan_state_t state_q;
  scan_state_t state_d;

  logic load;
  logic xfer;
  logic w_term;
  logic d_term;
  logic frame_end;
  logic w_en;
  logic d_en;

  assign frame_end = w_term && d_term;
  // The final transfer leaves the counters parked on the last coordinate.
  assign w_en      = xfer && !frame_end;
  assign d_en      = xfer && w_term && !frame_end;

  kernel_scan_counter #(
    .W     (AW_W),
    .FIRST (AW_W'(FIRST_W)),
    .LAST  (AW_W'(LAST_W))
  ) u_width_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .en_i   (w_en),
    .cnt_o  (address_width),
    .term_o (w_term)
  );

  kernel_scan_counter #(
    .W     (AD_W),
    .FIRST ('0),
    .LAST  (AD_W'(LAST_D))
  ) u_depth_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .en_i   (d_en),
    .cnt_o  (address_depth),
    .term_o (d_term)
  );

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    load      = 1'b0;
    xfer      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          load    = 1'b1;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        xfer      = out_ready;
        if (out_ready && frame_end) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign last       = out_valid && frame_end;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_kernel_address_scanner.sv
// tb/tb_kernel_address_scanner.sv - scoreboard bench for kernel_address_scanner, honours KERNEL_SCAN_BORDER_SKIP_EN
module tb_kernel_address_scanner;

  localparam int IMG_W = 4;
  localparam int IMG_D = 3;
  localparam int AW_W  = 8;
  localparam int AD_W  = 8;

`ifdef KERNEL_SCAN_BORDER_SKIP_EN
  localparam int EXP_FW = 1;
  localparam int EXP_LW = IMG_W - 2;
  localparam int EXP_LD = IMG_D - 2;
`else
  localparam int EXP_FW = 0;
  localparam int EXP_LW = IMG_W - 1;
  localparam int EXP_LD = IMG_D - 1;
`endif
  localparam int NPAIRS = (EXP_LW - EXP_FW + 1) * (EXP_LD + 1);

  typedef struct {
    int x;
    int y;
    bit last;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            out_ready;
  logic            out_valid;
  logic [AW_W-1:0] address_width;
  logic [AD_W-1:0] address_depth;
  logic            last;
  logic            busy;
  logic            frame_done;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  kernel_address_scanner #(
    .IMG_W (IMG_W),
    .IMG_D (IMG_D),
    .AW_W  (AW_W),
    .AD_W  (AD_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .address_width (address_width),
    .address_depth (address_depth),
    .last          (last),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_last"}, last, 0);
  endtask

  task automatic push_frame();
    exp_t e;
    for (int y = 0; y <= EXP_LD; y++) begin
      for (int x = EXP_FW; x <= EXP_LW; x++) begin
        e.x    = x;
        e.y    = y;
        e.last = (x == EXP_LW) && (y == EXP_LD);
        sb.push_back(e);
      end
    end
  endtask

  // mode 0: ready high; 1: ready toggles 1/0; 2: ready low for 10 cycles then high.
  task automatic run_frame(input string tag, input int mode, input int scan_start_at,
                           input bit start_in_done, input int exp_valid_cycles);
    int   cyc = 0;
    int   valid_cycles = 0;
    bit   got_last = 0;
    exp_t e;
    push_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!got_last && cyc < 200 && sb.size() != 0) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = (cyc >= 10);
      endcase
      start = (cyc == scan_start_at);
      if (out_valid) valid_cycles++;
      e = sb[0];
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_done_low"}, frame_done, 0);
      check({tag, "_x"}, address_width, e.x);
      check({tag, "_y"}, address_depth, e.y);
      check({tag, "_lastflag"}, last, e.last);
      if (out_ready) begin
        void'(sb.pop_front());
        got_last = e.last;
      end
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check({tag, "_last_seen"}, got_last, 1);
    check({tag, "_sb_drained"}, sb.size(), 0);
    check({tag, "_valid_cycles"}, valid_cycles, exp_valid_cycles);
    check({tag, "_done_valid"}, out_valid, 0);
    check({tag, "_done_pulse"}, frame_done, 1);
    check({tag, "_done_busy"}, busy, 1);
    check({tag, "_done_lastlow"}, last, 0);
    start = start_in_done;
    @(negedge clk);
    start = 1'b0;
    check_idle({tag, "_post1"});
    @(negedge clk);
    check_idle({tag, "_post2"});
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_x", address_width, 0);
    check("rst_y", address_depth, 0);
    check_idle("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle_no_start");

    run_frame("full", 0, -1, 1'b0, NPAIRS);
    run_frame("toggle", 1, -1, 1'b0, 2 * NPAIRS - 1);
    run_frame("stall10", 2, -1, 1'b0, NPAIRS + 10);
    run_frame("start_scan", 0, 2, 1'b1, NPAIRS);

    // Abandon a frame mid-scan with an asynchronous reset.
    push_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5 && sb.size() != 0; i++) begin
      check("pre_rst_x", address_width, sb[0].x);
      check("pre_rst_y", address_depth, sb[0].y);
      void'(sb.pop_front());
      @(negedge clk);
    end
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", address_width, 0);
    check("arst_y", address_depth, 0);
    check_idle("arst");
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_hold_done", frame_done, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle("after_rst");
    end
    run_frame("restart", 0, -1, 1'b0, NPAIRS);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
